// File: rtl/sp_ctrl_pkg.sv
// Shared definitions for the single-precision issue controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: op-class enum, pipeline latencies, slot count, register
// address width, the reservation slot struct, and small helpers that map
// an op class to its writeback latency and to whether it reserves a slot.
package sp_ctrl_pkg;

    localparam int unsigned FP_LAT    = 6;
    localparam int unsigned INT_LAT   = 7;
    localparam int unsigned NUM_SLOTS = 7;
    localparam int unsigned REG_AW    = 7;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_FP  = 2'd1,
        CLS_INT = 2'd2,
        CLS_RSV = 2'd3
    } op_class_e;

    // Register addresses are numbered with bit 0 as the MSB.
    typedef logic [0:REG_AW-1] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rt_addr;
        op_class_e cls;
    } slot_t;

    // Writeback latency in cycles; only meaningful for FP and INT.
    function automatic logic [2:0] class_lat(input op_class_e c);
        return (c == CLS_INT) ? 3'(INT_LAT) : 3'(FP_LAT);
    endfunction

    // Only register-writing FP/INT ops occupy a writeback slot. Everything
    // else (NOP, the reserved encoding, non-writing ops) flows straight
    // through without any hazard checking.
    function automatic logic class_reserves(input op_class_e c, input logic reg_write);
        return reg_write && ((c == CLS_FP) || (c == CLS_INT));
    endfunction

endpackage

// File: rtl/sp_hazard_cmp.sv
// Compares one reservation slot against an incoming instruction.
// Latency: purely combinational.
// Backpressure: none; the hits feed the stall decision in the parent.
//
// Ports:
//   slot                  reservation slot S<SLOT_IDX> contents
//   ra/rb/rc_addr         source register addresses of the offered op
//   src_use               source enable mask, bit0=ra, bit1=rb, bit2=rc
//   rt_addr               destination of the offered op
//   lat                   writeback latency of the offered op
//   raw_hit               an enabled source reads this slot's pending rt
//   waw_hit               same rt, and this slot retires no earlier than
//                         the new op would (k >= lat)
module sp_hazard_cmp
    import sp_ctrl_pkg::*;
#(
    parameter int unsigned SLOT_IDX = 1
) (
    input  slot_t        slot,
    input  reg_addr_t    ra_addr,
    input  reg_addr_t    rb_addr,
    input  reg_addr_t    rc_addr,
    input  logic [2:0]   src_use,
    input  reg_addr_t    rt_addr,
    input  logic [2:0]   lat,
    output logic         raw_hit,
    output logic         waw_hit
);

    logic ra_hit;
    logic rb_hit;
    logic rc_hit;

    assign ra_hit = src_use[0] && (ra_addr == slot.rt_addr);
    assign rb_hit = src_use[1] && (rb_addr == slot.rt_addr);
    assign rc_hit = src_use[2] && (rc_addr == slot.rt_addr);

    // S1 is included: there is no forwarding, so a value retiring this
    // cycle is not yet readable by an op issuing this cycle.
    assign raw_hit = slot.valid && (ra_hit || rb_hit || rc_hit);

    // A younger writer must not retire before or together with an older
    // writer of the same register.
    assign waw_hit = slot.valid
                  && (rt_addr == slot.rt_addr)
                  && (3'(SLOT_IDX) >= lat);

endmodule

// File: rtl/sp_issue_ctrl.sv
// Issue/hazard controller for the single-precision unit: 7-deep writeback reservation shift register.
// Latency: in_ready/issue_fire combinational; FP writes back 6 cycles after accept, INT 7.
// Backpressure: in_ready drops on RAW/WAW/structural hazard, flush or reset; requester holds the op.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   flush                 drop every reservation at the next edge
//   in_valid/in_class     offered op and its class (0 NOP, 1 FP, 2 INT, 3 NOP)
//   in_rt/ra/rb/rc_addr   destination and source registers (bit 0 MSB)
//   in_src_use            source enables, bit0=ra, bit1=rb, bit2=rc
//   in_reg_write          op writes the register file
//   in_ready, issue_fire  accept permission and actual accept
//   wb_valid/rt/class     registered writeback announcement from slot S1
//   inflight_cnt          registered number of valid slots
module sp_issue_ctrl
    import sp_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [1:0]          in_class,
    input  logic [0:REG_AW-1]   in_rt_addr,
    input  logic [0:REG_AW-1]   in_ra_addr,
    input  logic [0:REG_AW-1]   in_rb_addr,
    input  logic [0:REG_AW-1]   in_rc_addr,
    input  logic [2:0]          in_src_use,
    input  logic                in_reg_write,
    output logic                in_ready,
    output logic                issue_fire,
    output logic                wb_valid,
    output logic [0:REG_AW-1]   wb_rt_addr,
    output logic [1:0]          wb_class,
    output logic [CNT_W-1:0]    inflight_cnt
);

    // Sk holds the op that writes back k cycles from now; S1 is this cycle.
    slot_t              slot_q [1:NUM_SLOTS];
    slot_t              slot_d [1:NUM_SLOTS];

    op_class_e          cls;
    logic               reserves;
    logic [2:0]         lat;
    logic [NUM_SLOTS:1] raw_vec;
    logic [NUM_SLOTS:1] waw_vec;
    logic               struct_hz;
    logic               hazard;
    slot_t              new_slot;
    logic [CNT_W-1:0]   cnt_d;

    assign cls      = op_class_e'(in_class);
    assign reserves = class_reserves(cls, in_reg_write);
    assign lat      = class_lat(cls);

    // ------------------------------------------------------------------
    // Per-slot hazard comparison
    // ------------------------------------------------------------------
    for (genvar k = 1; k <= NUM_SLOTS; k++) begin : g_cmp
        sp_hazard_cmp #(
            .SLOT_IDX (k)
        ) u_cmp (
            .slot     (slot_q[k]),
            .ra_addr  (in_ra_addr),
            .rb_addr  (in_rb_addr),
            .rc_addr  (in_rc_addr),
            .src_use  (in_src_use),
            .rt_addr  (in_rt_addr),
            .lat      (lat),
            .raw_hit  (raw_vec[k]),
            .waw_hit  (waw_vec[k])
        );
    end

    // An FP op lands in S6 at the edge, which is exactly where the current
    // S7 shifts to; INT lands in S7, which is always vacated by the shift.
    assign struct_hz = (cls == CLS_FP) && slot_q[NUM_SLOTS].valid;

    // Non-reserving ops never stall on hazards; only flush/reset block them.
    assign hazard     = reserves && (struct_hz || (|raw_vec) || (|waw_vec));
    assign in_ready   = !reset && !flush && !hazard;
    assign issue_fire = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next slot state: shift toward S1, then insert the accepted op
    // ------------------------------------------------------------------
    always_comb begin
        new_slot         = '0;
        new_slot.valid   = 1'b1;
        new_slot.rt_addr = in_rt_addr;
        new_slot.cls     = cls;

        for (int k = 1; k < NUM_SLOTS; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[NUM_SLOTS] = '0;

        if (issue_fire && reserves) begin
            if (cls == CLS_INT) begin
                slot_d[INT_LAT] = new_slot;
            end else begin
                slot_d[FP_LAT] = new_slot;
            end
        end

        // Population after the edge, so a simultaneous retire and insert
        // are both reflected.
        cnt_d = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, slot_d[k].valid};
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Flush clears the whole slot, not just the valid bit, so the
    // writeback fields read as zero whenever nothing is in flight.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
            inflight_cnt <= '0;
        end else begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
            inflight_cnt <= cnt_d;
        end
    end

    assign wb_valid   = slot_q[1].valid;
    assign wb_rt_addr = slot_q[1].rt_addr;
    assign wb_class   = slot_q[1].cls;

endmodule

// File: tb/tb_sp_issue_ctrl.sv
// Self-checking bench for sp_issue_ctrl: directed scenarios with literal
// expectations, plus a due-time reservation model checked every cycle.
module tb_sp_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_class;
    logic [0:6]  in_rt_addr;
    logic [0:6]  in_ra_addr;
    logic [0:6]  in_rb_addr;
    logic [0:6]  in_rc_addr;
    logic [2:0]  in_src_use;
    logic        in_reg_write;
    logic        in_ready;
    logic        issue_fire;
    logic        wb_valid;
    logic [0:6]  wb_rt_addr;
    logic [1:0]  wb_class;
    logic [2:0]  inflight_cnt;

    always #5 clk = ~clk;

    sp_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_class     (in_class),
        .in_rt_addr   (in_rt_addr),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rc_addr   (in_rc_addr),
        .in_src_use   (in_src_use),
        .in_reg_write (in_reg_write),
        .in_ready     (in_ready),
        .issue_fire   (issue_fire),
        .wb_valid     (wb_valid),
        .wb_rt_addr   (wb_rt_addr),
        .wb_class     (wb_class),
        .inflight_cnt (inflight_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each reservation is a (rt, class, due cycle) record. In cycle
    // t a record sits in slot position k = due - t + 1.
    // ------------------------------------------------------------------
    typedef struct {
        int rt;
        int cls;
        int due;
    } res_t;

    res_t q[$];

    always @(negedge clk) begin : model
        bit   exp_ready;
        bit   resv;
        bit   exp_wb;
        int   lat;
        int   k;
        int   exp_rt;
        int   exp_cls;
        res_t r;
        if (chk_en) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].due < cyc) q.delete(i);
            end

            resv      = in_reg_write && (in_class == 2'd1 || in_class == 2'd2);
            lat       = (in_class == 2'd2) ? 7 : 6;
            exp_ready = !(reset || flush);
            if (exp_ready && resv) begin
                foreach (q[i]) begin
                    k = q[i].due - cyc + 1;
                    if (in_class == 2'd1 && k == 7) exp_ready = 1'b0;
                    if ((in_src_use[0] && int'(in_ra_addr) == q[i].rt) ||
                        (in_src_use[1] && int'(in_rb_addr) == q[i].rt) ||
                        (in_src_use[2] && int'(in_rc_addr) == q[i].rt))
                        exp_ready = 1'b0;
                    if (int'(in_rt_addr) == q[i].rt && k >= lat) exp_ready = 1'b0;
                end
            end

            exp_wb  = 1'b0;
            exp_rt  = 0;
            exp_cls = 0;
            foreach (q[i]) begin
                if (q[i].due == cyc) begin
                    exp_wb  = 1'b1;
                    exp_rt  = q[i].rt;
                    exp_cls = q[i].cls;
                end
            end

            chk($sformatf("model in_ready @%0d", cyc), in_ready, exp_ready);
            chk($sformatf("model issue_fire @%0d", cyc), issue_fire, in_valid && exp_ready);
            chk($sformatf("model wb_valid @%0d", cyc), wb_valid, exp_wb);
            if (exp_wb) begin
                chk($sformatf("model wb_rt_addr @%0d", cyc), int'(wb_rt_addr), exp_rt);
                chk($sformatf("model wb_class @%0d", cyc), int'(wb_class), exp_cls);
            end
            chk($sformatf("model inflight_cnt @%0d", cyc), int'(inflight_cnt), q.size());

            if (reset || flush) begin
                q.delete();
            end else if (in_valid && exp_ready && resv) begin
                r.rt  = int'(in_rt_addr);
                r.cls = int'(in_class);
                r.due = cyc + lat;
                q.push_back(r);
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Driver helpers; the driver always sits at posedge+1 between calls.
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int cls, input int rt, input int ra, input int rb,
                         input int rc, input int use_m, input int wr);
        in_valid     = 1'b1;
        in_class     = 2'(cls);
        in_rt_addr   = 7'(rt);
        in_ra_addr   = 7'(ra);
        in_rb_addr   = 7'(rb);
        in_rc_addr   = 7'(rc);
        in_src_use   = 3'(use_m);
        in_reg_write = 1'(wr);
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_class     = 2'd0;
        in_rt_addr   = '0;
        in_ra_addr   = '0;
        in_rb_addr   = '0;
        in_rc_addr   = '0;
        in_src_use   = '0;
        in_reg_write = 1'b0;
    endtask

    task automatic idle_n(input int n);
        idle();
        repeat (n) tick();
    endtask

    // Holds the current offer until it fires or the budget runs out;
    // 'at' is the relative cycle of the accept, or -1 on timeout.
    task automatic hold_until_fire(input int start, input int limit, output int at);
        at = -1;
        for (int c = start; c < start + limit; c++) begin
            #1;
            if (issue_fire) begin
                at = c;
                break;
            end
            tick();
        end
        if (at >= 0) tick();
        idle();
    endtask

    typedef struct {
        int cls; int rt; int ra; int rb; int rc; int use_m; int wr;
    } vec_t;

    vec_t mix[8] = '{
        '{2, 40,  0,  0,  0, 0, 1},
        '{1, 41,  0, 40,  0, 2, 1},
        '{2, 41,  0,  0,  0, 0, 1},
        '{1, 42,  0,  0, 41, 4, 1},
        '{0, 42, 42, 42, 42, 7, 1},
        '{1,  0, 42,  0,  0, 1, 0},
        '{2, 43, 42,  0,  0, 1, 1},
        '{1, 43,  0,  0,  0, 0, 1}
    };

    initial begin : stim
        int at;
        reset = 1'b1;
        flush = 1'b0;
        idle();

        // Reset: in_ready low while reset is high, clean outputs after.
        @(posedge clk);
        #1;
        offer(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset issue_fire", issue_fire, 0);
        tick();
        reset  = 1'b0;
        idle();
        chk_en = 1'b1;
        #1;
        chk("post-reset wb_valid", wb_valid, 0);
        chk("post-reset wb_rt_addr", int'(wb_rt_addr), 0);
        chk("post-reset wb_class", int'(wb_class), 0);
        chk("post-reset inflight_cnt", int'(inflight_cnt), 0);
        tick();

        // FP rt=3 at cycle 0 writes back in cycle 6 only.
        offer(1, 3, 0, 0, 0, 0, 1);
        #1;
        chk("A ready c0", in_ready, 1);
        chk("A fire c0", issue_fire, 1);
        chk("A cnt c0", int'(inflight_cnt), 0);
        tick();
        idle();
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("A wb_valid c%0d", c), wb_valid, (c == 6) ? 1 : 0);
            chk($sformatf("A cnt c%0d", c), int'(inflight_cnt), (c <= 6) ? 1 : 0);
            if (c == 6) begin
                chk("A wb_rt_addr c6", int'(wb_rt_addr), 3);
                chk("A wb_class c6", int'(wb_class), 1);
            end
            tick();
        end

        // INT rt=5 then FP rt=6: structural stall in cycle 1.
        offer(2, 5, 0, 0, 0, 0, 1);
        #1;
        chk("B int fire c0", issue_fire, 1);
        tick();
        offer(1, 6, 0, 0, 0, 0, 1);
        #1;
        chk("B fp ready c1", in_ready, 0);
        tick();
        #1;
        chk("B fp fire c2", issue_fire, 1);
        tick();
        idle();
        for (int c = 3; c <= 9; c++) begin
            #1;
            chk($sformatf("B wb_valid c%0d", c), wb_valid, (c == 7 || c == 8) ? 1 : 0);
            if (c == 7) chk("B wb_rt_addr c7", int'(wb_rt_addr), 5);
            if (c == 7) chk("B wb_class c7", int'(wb_class), 2);
            if (c == 8) chk("B wb_rt_addr c8", int'(wb_rt_addr), 6);
            if (c == 8) chk("B wb_class c8", int'(wb_class), 1);
            tick();
        end

        // RAW on ra=3: stalls through the S1 retire cycle, accepts in 7.
        offer(1, 3, 0, 0, 0, 0, 1);
        #1;
        chk("C producer fire", issue_fire, 1);
        tick();
        offer(1, 10, 3, 0, 0, 1, 1);
        hold_until_fire(1, 20, at);
        chk("C raw accept cycle", at, 7);
        idle_n(8);

        // WAW + structural on rt=9 behind an INT.
        offer(2, 9, 0, 0, 0, 0, 1);
        #1;
        chk("D int fire", issue_fire, 1);
        tick();
        offer(1, 9, 0, 0, 0, 0, 1);
        hold_until_fire(1, 20, at);
        chk("D waw accept cycle", at, 3);
        idle_n(10);

        // Three FP in flight, then flush; then the same with reset.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                offer(1, 20 + i, 0, 0, 0, 0, 1);
                #1;
                chk($sformatf("E%0d fire %0d", pass, i), issue_fire, 1);
                tick();
            end
            offer(1, 23, 0, 0, 0, 0, 1);
            if (pass == 0) flush = 1'b1;
            else           reset = 1'b1;
            #1;
            chk($sformatf("E%0d cnt before drop", pass), int'(inflight_cnt), 3);
            chk($sformatf("E%0d ready during drop", pass), in_ready, 0);
            tick();
            flush = 1'b0;
            reset = 1'b0;
            idle();
            #1;
            chk($sformatf("E%0d cnt after drop", pass), int'(inflight_cnt), 0);
            chk($sformatf("E%0d wb_rt_addr after drop", pass), int'(wb_rt_addr), 0);
            for (int c = 0; c < 8; c++) begin
                #1;
                chk($sformatf("E%0d wb_valid +%0d", pass, c), wb_valid, 0);
                tick();
            end
        end

        // Fill all seven slots with INT, then offer non-reserving ops.
        for (int i = 0; i < 7; i++) begin
            offer(2, 30 + i, 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("F fill fire %0d", i), issue_fire, 1);
            tick();
        end
        for (int c = 7; c <= 13; c++) begin
            case (c % 4)
                0:       offer(0, 31, 31, 32, 33, 7, 1);
                1:       offer(3, 36, 36, 35, 34, 7, 1);
                2:       offer(1, 36, 30, 35, 36, 7, 0);
                default: offer(2, 36, 33, 34, 35, 7, 0);
            endcase
            #1;
            chk($sformatf("F ready c%0d", c), in_ready, 1);
            chk($sformatf("F cnt c%0d", c), int'(inflight_cnt), 14 - c);
            tick();
        end
        idle_n(3);

        // Mixed sequence, each op held until accepted.
        foreach (mix[i]) begin
            offer(mix[i].cls, mix[i].rt, mix[i].ra, mix[i].rb, mix[i].rc,
                  mix[i].use_m, mix[i].wr);
            hold_until_fire(0, 25, at);
            chk($sformatf("G op %0d accepted", i), (at >= 0) ? 1 : 0, 1);
        end
        idle_n(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test by 100000ns, want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
